// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle test processor:
// FSM state enum, opcode values, instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Ops that end in a register write (go through WRITEBACK).
    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: ADD/ADDI, SUB, AND, OR, pass-b for LDI.
// Ports: op (opcode), a, b (operands), y (result, wraps mod 2**DATA_W).
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_LDI:  y = b;
            OP_ADD:  y = a + b;
            OP_ADDI: y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle test processor: FETCH/DECODE/EXECUTE/WRITEBACK FSM,
// 4-entry register file, IMEM loaded through prog_* while rst=1.
// Ports: clk, rst (sync, active-high), prog_we/prog_addr/prog_data,
// result (last register write), pc_out, halted.
// Optional CPU_TRACE_EN macro adds retire_valid/retire_pc/retire_instr.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [DATA_W-1:0]  result,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
`ifdef CPU_TRACE_EN
    ,
    output logic               retire_valid,
    output logic [PC_W-1:0]    retire_pc,
    output logic [INSTR_W-1:0] retire_instr
`endif
);

    localparam int DEPTH = 1 << PC_W;

    logic [INSTR_W-1:0] imem [DEPTH];

    state_t             state, state_n;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  regs [4];
    logic [DATA_W-1:0]  op_a, op_b;
    logic [DATA_W-1:0]  alu_out, alu_y;
    logic [DATA_W-1:0]  imm_ext;
    logic [3:0]         op;
    logic [1:0]         rd, rs;
    logic [PC_W-1:0]    tgt;
    logic               writes, takes_imm, taken;

    assign op      = instr[OP_HI:OP_LO];
    assign rd      = instr[RD_HI:RD_LO];
    assign rs      = instr[RS_HI:RS_LO];
    assign imm_ext = DATA_W'(instr[IMM_HI:IMM_LO]);
    assign tgt     = instr[IMM_LO +: PC_W];

    assign writes    = is_alu(op);
    assign takes_imm = (op == OP_LDI) || (op == OP_ADDI);
    // op_a holds reg[rd] latched in DECODE, so BEQZ tests it here.
    assign taken     = (op == OP_JMP) ||
                       ((op == OP_BEQZ) && (op_a == '0));

    assign pc_out = pc;

    // IMEM is only writable while the core is held in reset.
    always_ff @(posedge clk) begin
        if (rst && prog_we)
            imem[prog_addr] <= prog_data;
    end

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            FETCH:     state_n = DECODE;
            DECODE:    state_n = EXECUTE;
            EXECUTE: begin
                if (writes)
                    state_n = WRITEBACK;
                else if (op == OP_HALT)
                    state_n = HALT;
                else
                    state_n = FETCH;
            end
            WRITEBACK: state_n = FETCH;
            HALT:      state_n = HALT;
            default:   state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= '0;
            instr   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            alu_out <= '0;
            result  <= '0;
            halted  <= 1'b0;
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else begin
            state  <= state_n;
            // Registered: rises the cycle after HALT is entered.
            halted <= (state == HALT);
            case (state)
                FETCH: begin
                    instr <= imem[pc];
                    pc    <= pc + 1'b1;
                end
                DECODE: begin
                    op_a <= regs[rd];
                    op_b <= takes_imm ? imm_ext : regs[rs];
                end
                EXECUTE: begin
                    alu_out <= alu_y;
                    if (taken)
                        pc <= tgt;
                end
                WRITEBACK: begin
                    regs[rd] <= alu_out;
                    result   <= alu_out;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_TRACE_EN
    logic [PC_W-1:0] fpc;

    always_ff @(posedge clk) begin
        if (rst)
            fpc <= '0;
        else if (state == FETCH)
            fpc <= pc;
    end

    assign retire_valid = (state == WRITEBACK) ||
                          ((state == EXECUTE) && !writes);
    assign retire_pc    = fpc;
    assign retire_instr = instr;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: small DUT (DATA_W=8, PC_W=4)
// scoreboarded on result timing, plus a default-size DUT spot-checked.
module tb_cpu_multicycle;
    import cpu_pkg::*;

    logic        clk = 0;
    logic        rst = 1;
    logic        prog_we = 0;
    logic [3:0]  prog_addr = 0;
    logic [15:0] prog_data = 0;
    logic [7:0]  prog_addr_b;

    logic [7:0]  result;
    logic [3:0]  pc_out;
    logic        halted;
    logic [31:0] result_b;
    logic [7:0]  pc_out_b;
    logic        halted_b;

    assign prog_addr_b = {4'h0, prog_addr};

    always #5 clk = ~clk;

`ifdef CPU_TRACE_EN
    logic        rv, rv_b;
    logic [3:0]  rpc;
    logic [7:0]  rpc_b;
    logic [15:0] rins, rins_b;
`endif

    cpu_multicycle #(.DATA_W(8), .PC_W(4), .INSTR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .result    (result),
        .pc_out    (pc_out),
        .halted    (halted)
`ifdef CPU_TRACE_EN
        ,
        .retire_valid (rv),
        .retire_pc    (rpc),
        .retire_instr (rins)
`endif
    );

    cpu_multicycle dut_b (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr_b),
        .prog_data (prog_data),
        .result    (result_b),
        .pc_out    (pc_out_b),
        .halted    (halted_b)
`ifdef CPU_TRACE_EN
        ,
        .retire_valid (rv_b),
        .retire_pc    (rpc_b),
        .retire_instr (rins_b)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         at;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Pop an expected write when its cycle comes up.
    always @(negedge clk) begin
        if (!rst && sb.size() > 0 && cyc == sb[0].at) begin
            e = sb.pop_front();
            chk("result", {24'h0, result}, {24'h0, e.v});
        end
    end

    task automatic push(input int at, input logic [7:0] v);
        exp_t x;
        x.at = at;
        x.v  = v;
        sb.push_back(x);
    endtask

`ifdef CPU_TRACE_EN
    typedef struct {
        logic [3:0]  pc;
        logic [15:0] ins;
    } ret_t;

    ret_t tq[$];
    ret_t r;
    bit   tr_en = 0;

    always @(negedge clk) begin
        if (!rst && tr_en && rv) begin
            if (tq.size() == 0) begin
                chk("tr_extra", 32'd1, 32'd0);
            end else begin
                r = tq.pop_front();
                chk("tr_pc", {28'h0, rpc}, {28'h0, r.pc});
                chk("tr_ins", {16'h0, rins}, {16'h0, r.ins});
            end
        end
    end
`endif

    logic [15:0] img [16];

    function automatic logic [15:0] ins(input logic [3:0] op,
                                        input logic [1:0] rd,
                                        input logic [1:0] rs,
                                        input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic clr_img();
        for (int i = 0; i < 16; i++)
            img[i] = 16'h0000;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1;
            prog_addr = 4'(i);
            prog_data = img[i];
            @(negedge clk);
        end
        prog_we = 0;
        rst     = 0;
        sb.delete();
        chk("rst_res", {24'h0, result}, 32'h0);
        chk("rst_pc", {28'h0, pc_out}, 32'h0);
        chk("rst_halt", {31'h0, halted}, 32'h0);
    endtask

    task automatic load_t1();
        clr_img();
        img[0] = ins(OP_LDI, 2'd0, 2'd0, 8'd5);
        img[1] = ins(OP_LDI, 2'd1, 2'd0, 8'd3);
        img[2] = ins(OP_ADD, 2'd0, 2'd1, 8'd0);
        img[3] = ins(OP_HALT, 2'd0, 2'd0, 8'd0);
    endtask

    initial begin
        // Test 1: basic program, latency, halt
        load_t1();
`ifdef CPU_TRACE_EN
        for (int i = 0; i < 4; i++) begin
            ret_t t;
            t.pc  = 4'(i);
            t.ins = img[i];
            tq.push_back(t);
        end
        tr_en = 1;
`endif
        do_reset();
`ifdef CPU_TRACE_EN
        chk("tr_rst_v", {31'h0, rv}, 32'h0);
        chk("tr_rst_pc", {28'h0, rpc}, 32'h0);
`endif
        push(4, 8'd5);
        push(8, 8'd3);
        push(12, 8'd8);
        run(15);
        chk("t1_halt15", {31'h0, halted}, 32'h0);
        run(1);
        chk("t1_halt", {31'h0, halted}, 32'h1);
        chk("t1_pc", {28'h0, pc_out}, 32'h4);
        chk("t1_b_res", result_b, 32'h8);
        chk("t1_b_pc", {24'h0, pc_out_b}, 32'h4);
        chk("t1_b_halt", {31'h0, halted_b}, 32'h1);
        run(5);
        chk("t1_frz_pc", {28'h0, pc_out}, 32'h4);
        chk("t1_frz_res", {24'h0, result}, 32'h8);
        chk("t1_sb", sb.size(), 0);
`ifdef CPU_TRACE_EN
        tr_en = 0;
        chk("tr_left", tq.size(), 0);
`endif

        // Test 2a: 8-bit wrap on ADDI and SUB
        clr_img();
        img[0] = ins(OP_LDI, 2'd0, 2'd0, 8'hFF);
        img[1] = ins(OP_ADDI, 2'd0, 2'd0, 8'h02);
        img[2] = ins(OP_SUB, 2'd1, 2'd0, 8'h00);
        img[3] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
        do_reset();
        push(4, 8'hFF);
        push(8, 8'h01);
        push(12, 8'hFF);
        run(16);
        chk("t2_halt", {31'h0, halted}, 32'h1);
        chk("t2_b_res", result_b, 32'hFFFF_FEFF);
        chk("t2_sb", sb.size(), 0);

        // Test 2b: rd==rs doubling, AND, OR
        clr_img();
        img[0] = ins(OP_LDI, 2'd1, 2'd0, 8'h21);
        img[1] = ins(OP_ADD, 2'd1, 2'd1, 8'h00);
        img[2] = ins(OP_LDI, 2'd2, 2'd0, 8'hF0);
        img[3] = ins(OP_AND, 2'd2, 2'd1, 8'h00);
        img[4] = ins(OP_OR, 2'd2, 2'd1, 8'h00);
        img[5] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
        do_reset();
        push(4, 8'h21);
        push(8, 8'h42);
        push(12, 8'hF0);
        push(16, 8'h40);
        push(20, 8'h42);
        run(24);
        chk("t2b_halt", {31'h0, halted}, 32'h1);
        chk("t2b_pc", {28'h0, pc_out}, 32'h6);
        chk("t2b_sb", sb.size(), 0);

        // Test 3: countdown loop with BEQZ/JMP
        clr_img();
        img[0] = ins(OP_LDI, 2'd0, 2'd0, 8'd3);
        img[1] = ins(OP_LDI, 2'd2, 2'd0, 8'd1);
        img[2] = ins(OP_SUB, 2'd0, 2'd2, 8'd0);
        img[3] = ins(OP_BEQZ, 2'd0, 2'd0, 8'd6);
        img[4] = ins(OP_JMP, 2'd0, 2'd0, 8'd2);
        img[5] = ins(OP_NOP, 2'd0, 2'd0, 8'd0);
        img[6] = ins(OP_HALT, 2'd0, 2'd0, 8'd0);
        do_reset();
        push(4, 8'd3);
        push(8, 8'd1);
        push(12, 8'd2);
        push(22, 8'd1);
        push(32, 8'd0);
        run(38);
        chk("t3_halt38", {31'h0, halted}, 32'h0);
        run(1);
        chk("t3_halt", {31'h0, halted}, 32'h1);
        chk("t3_pc", {28'h0, pc_out}, 32'h7);
        chk("t3_res", {24'h0, result}, 32'h0);
        chk("t3_b_res", result_b, 32'h0);
        chk("t3_b_pc", {24'h0, pc_out_b}, 32'h7);
        chk("t3_sb", sb.size(), 0);

        // Test 4: PC wrap and undefined opcode
        clr_img();
        img[0] = ins(OP_LDI, 2'd0, 2'd0, 8'h77);
        img[3] = 16'hA000;
        do_reset();
        push(4, 8'h77);
        run(13);
        chk("t4_pc13", {28'h0, pc_out}, 32'h4);
        run(1);
        chk("t4_pc14", {28'h0, pc_out}, 32'h5);
        run(32);
        chk("t4_pc46", {28'h0, pc_out}, 32'hF);
        run(1);
        chk("t4_wrap", {28'h0, pc_out}, 32'h0);
        chk("t4_res", {24'h0, result}, 32'h77);
        chk("t4_sb", sb.size(), 0);

        // Test 5: reset during EXECUTE; prog_we ignored out of reset
        load_t1();
        do_reset();
        push(4, 8'd5);
        push(8, 8'd3);
        prog_we   = 1;
        prog_addr = 4'd1;
        prog_data = ins(OP_HALT, 2'd0, 2'd0, 8'd0);
        run(3);
        prog_we = 0;
        run(7);
        rst = 1;
        run(1);
        chk("t5_res", {24'h0, result}, 32'h0);
        chk("t5_pc", {28'h0, pc_out}, 32'h0);
        chk("t5_halt", {31'h0, halted}, 32'h0);
        chk("t5_sb0", sb.size(), 0);
        rst = 0;
        push(4, 8'd5);
        push(8, 8'd3);
        push(12, 8'd8);
        run(1);
        chk("t5_fetch", {28'h0, pc_out}, 32'h1);
        run(15);
        chk("t5_fhalt", {31'h0, halted}, 32'h1);
        chk("t5_fpc", {28'h0, pc_out}, 32'h4);
        chk("t5_sb", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=0", cyc);
        $fatal(1);
    end

endmodule
